// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge
//   Bridges a four-phase CPU strobe bus onto a synchronous single-cycle RAM
//   and an 8-bit acknowledged I/O window. Addresses whose [31:8] equals
//   IO_PAGE go to I/O (this wins over RAM); addresses below 2^RAM_AW go to
//   RAM; anything else is unmapped: it completes at once and sets a sticky
//   error flag.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cpu_req/we/addr/wdata     CPU request (latched on acceptance)
//   o_cpu_rdata, o_cpu_ready    CPU response; rdata valid while ready=1
//   o_ram_en/we/addr/wdata      RAM strobe, one cycle per access
//   i_ram_rdata                 RAM read data, one cycle after the strobe
//   o_io_req/we/addr/wdata      I/O request, held until ack or timeout
//   i_io_rdata, i_io_ack        I/O response
//   o_err, i_err_clr            sticky error flag and its synchronous clear
//
// RAM_AW must be at least 8: the I/O address is taken from the low byte of
// the latched address.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for i_cpu_req; request fields latched on accept
// S_RAM_ACC | RAM strobe cycle
// S_RAM_RD  | RAM read data arrives and is captured
// S_IO_WAIT | I/O request held; counting cycles toward IO_TIMEOUT
// S_DONE    | response held until the CPU drops i_cpu_req

module cpu_bus_bridge #(
  parameter int unsigned RAM_AW     = 16,
  parameter logic [23:0] IO_PAGE    = 24'h00009F,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_io_req,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [7:0]        o_io_wdata,
  input  logic [7:0]        i_io_rdata,
  input  logic              i_io_ack,
  output logic              o_err,
  input  logic              i_err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_ACC,
    S_RAM_RD,
    S_IO_WAIT,
    S_DONE
  } state_t;

  localparam logic [8:0] TO_LIM = 9'(IO_TIMEOUT);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              set_err;
  logic              is_io;
  logic              is_ram;

  assign is_io  = (i_cpu_addr[31:8] == IO_PAGE);
  assign is_ram = ((i_cpu_addr >> RAM_AW) == 32'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    set_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cpu_req) begin
          we_d    = i_cpu_we;
          addr_d  = i_cpu_addr[RAM_AW-1:0];
          wdata_d = i_cpu_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (is_io) begin
            state_d = S_IO_WAIT;
          end else if (is_ram) begin
            state_d = S_RAM_ACC;
          end else begin
            state_d = S_DONE;
            set_err = 1'b1;
          end
        end
      end
      S_RAM_ACC: begin
        state_d = we_q ? S_DONE : S_RAM_RD;
      end
      S_RAM_RD: begin
        rdata_d = i_ram_rdata;
        state_d = S_DONE;
      end
      S_IO_WAIT: begin
        // ack is tested first so an ack on the terminal cycle completes normally
        if (i_io_ack) begin
          if (!we_q) rdata_d = {24'h0, i_io_rdata};
          state_d = S_DONE;
        end else if (({1'b0, cnt_q} + 9'd1) == TO_LIM) begin
          if (!we_q) rdata_d = 32'hFFFF_FFFF;
          set_err = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (ready_q && !i_cpu_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered, so it rises one cycle after DONE is entered and
  // falls on the edge that samples the CPU's released strobe.
  assign ready_d = (state_q == S_DONE) && !(ready_q && !i_cpu_req);

  // A same-cycle error event outranks the clear.
  assign err_d = set_err ? 1'b1 : (i_err_clr ? 1'b0 : err_q);

  assign o_cpu_rdata = rdata_q;
  assign o_cpu_ready = ready_q;
  assign o_ram_en    = (state_q == S_RAM_ACC);
  assign o_ram_we    = o_ram_en & we_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_io_req    = (state_q == S_IO_WAIT);
  assign o_io_we     = o_io_req & we_q;
  assign o_io_addr   = addr_q[7:0];
  assign o_io_wdata  = wdata_q[7:0];
  assign o_err       = err_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Testbench for cpu_bus_bridge: a transaction-level model predicts, for each
// request, the cycle at which ready rises, the cycles carrying RAM / I/O
// strobes, the read data and the error flag; every cycle the DUT outputs are
// compared against that prediction. Directed cases pin the model with
// hand-computed literals, then randomized transactions follow.

module tb_cpu_bus_bridge;

  localparam int RAM_AW = 16;
  localparam int T      = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cpu_req = 1'b0;
  logic        i_cpu_we = 1'b0;
  logic [31:0] i_cpu_addr = '0;
  logic [31:0] i_cpu_wdata = '0;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_ready;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [15:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;
  logic        o_io_req;
  logic        o_io_we;
  logic [7:0]  o_io_addr;
  logic [7:0]  o_io_wdata;
  logic [7:0]  i_io_rdata = '0;
  logic        i_io_ack = 1'b0;
  logic        o_err;
  logic        i_err_clr = 1'b0;

  cpu_bus_bridge #(.RAM_AW(RAM_AW), .IO_PAGE(24'h00009F), .IO_TIMEOUT(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ready(o_cpu_ready),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .o_io_req(o_io_req), .o_io_we(o_io_we), .o_io_addr(o_io_addr),
    .o_io_wdata(o_io_wdata), .i_io_rdata(i_io_rdata), .i_io_ack(i_io_ack),
    .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  // RAM device: synchronous, one-cycle read latency.
  logic [31:0] dev_mem [0:511];
  always @(posedge i_clk) begin
    if (o_ram_en) begin
      if (o_ram_we) dev_mem[o_ram_addr[8:0]] <= o_ram_wdata;
      else          i_ram_rdata <= dev_mem[o_ram_addr[8:0]];
    end
  end

  // model state
  logic [31:0] mdl_mem [0:511];
  int unsigned wr_q[$];
  bit          model_err;
  bit          clr_last;

  // per-cycle expectations
  bit          exp_ready, exp_ram_en, exp_io_req, exp_rdchk, exp_we;
  logic [31:0] exp_addr, exp_wd, exp_rdata;

  // observations of the last transaction
  int          obs_ready_p, obs_io_cycles, obs_ram_cycles;
  logic [31:0] obs_rdata;
  logic [7:0]  obs_io_addr;
  bit          obs_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL cycle_budget: got %0d cycles, expected at most 60000", cyc);
      $fatal(1);
    end
  endtask

  task automatic step_err(input bit set);
    if (set)           model_err = 1'b1;
    else if (clr_last) model_err = 1'b0;
  endtask

  task automatic set_idle();
    exp_ready  = 1'b0;
    exp_ram_en = 1'b0;
    exp_io_req = 1'b0;
    exp_rdchk  = 1'b0;
  endtask

  task automatic cmp_cycle();
    chk("ready", 32'(o_cpu_ready), 32'(exp_ready));
    chk("ram_en", 32'(o_ram_en), 32'(exp_ram_en));
    chk("io_req", 32'(o_io_req), 32'(exp_io_req));
    chk("err", 32'(o_err), 32'(model_err));
    if (exp_ram_en) begin
      chk("ram_we", 32'(o_ram_we), 32'(exp_we));
      chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr[15:0]));
      if (exp_we) chk("ram_wdata", o_ram_wdata, exp_wd);
    end
    if (exp_io_req) begin
      chk("io_we", 32'(o_io_we), 32'(exp_we));
      chk("io_addr", 32'(o_io_addr), 32'(exp_addr[7:0]));
      if (exp_we) chk("io_wdata", 32'(o_io_wdata), 32'(exp_wd[7:0]));
    end
    if (exp_rdchk) chk("rdata", o_cpu_rdata, exp_rdata);
  endtask

  // One complete transfer. Cycle p counts clock edges after the accepting
  // edge (p=0 is the cycle right after acceptance). ack_c is the cycle in
  // which i_io_ack is driven (-1: never).
  task automatic run_txn(input logic [31:0] a, input bit we, input logic [31:0] wd,
                         input int ack_c, input logic [7:0] io_rd, input int hold,
                         input bit rnd, input bit clr_acc, input bit skip_idle);
    bit          is_io, is_ram, clr;
    int          r, io_end, s, q;
    logic [31:0] exp_rd;
    is_io  = (a[31:8] == 24'h00009F);
    is_ram = !is_io && (a < 32'h0001_0000);
    s = -100; io_end = -1; r = 1; exp_rd = '0;
    if (is_io) begin
      if (ack_c >= 0 && ack_c <= T-1) begin
        io_end = ack_c; r = ack_c + 2; exp_rd = {24'h0, io_rd};
      end else begin
        io_end = T-1; r = T+1; s = T; exp_rd = 32'hFFFF_FFFF;
      end
    end else if (is_ram) begin
      r = we ? 2 : 3;
      exp_rd = mdl_mem[a[8:0]];
      if (we) begin
        mdl_mem[a[8:0]] = wd;
        wr_q.push_back(32'(a[8:0]));
      end
    end else begin
      r = 1; s = 0; exp_rd = '0;
    end
    q = r + hold;
    obs_ready_p = -1; obs_io_cycles = 0; obs_ram_cycles = 0;
    obs_rdata = '0; obs_io_addr = '0; obs_err = 1'b0;
    exp_addr = a; exp_we = we; exp_wd = wd; exp_rdata = exp_rd;

    // request presented in an idle cycle
    if (!skip_idle) begin
      tick();
      step_err(1'b0);
    end
    set_idle();
    i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = a; i_cpu_wdata = wd;
    clr = clr_acc | (rnd && $urandom_range(0, 5) == 0);
    i_err_clr = clr; clr_last = clr;
    i_io_ack = rnd && ($urandom_range(0, 3) == 0);
    i_io_rdata = 8'($urandom);
    #1 cmp_cycle();

    for (int p = 0; p <= q; p++) begin
      tick();
      step_err(p == s);
      exp_ram_en = is_ram && (p == 0);
      exp_io_req = is_io && (p <= io_end);
      exp_ready  = (p >= r);
      exp_rdchk  = exp_ready && !we;
      i_cpu_req   = (p < q);
      i_cpu_we    = 1'($urandom);
      i_cpu_addr  = $urandom;
      i_cpu_wdata = $urandom;
      if (is_io && p == ack_c) begin
        i_io_ack = 1'b1; i_io_rdata = io_rd;
      end else begin
        i_io_ack = rnd && (!is_io || p > io_end) && ($urandom_range(0, 2) == 0);
        i_io_rdata = 8'($urandom);
      end
      clr = rnd && ($urandom_range(0, 5) == 0);
      i_err_clr = clr; clr_last = clr;
      #1;
      cmp_cycle();
      if (o_cpu_ready && obs_ready_p < 0) begin
        obs_ready_p = p; obs_rdata = o_cpu_rdata; obs_err = o_err;
      end
      if (o_io_req) begin
        obs_io_cycles++; obs_io_addr = o_io_addr;
      end
      if (o_ram_en) obs_ram_cycles++;
    end
  endtask

  task automatic idle_cyc(input bit clr);
    tick();
    step_err(1'b0);
    set_idle();
    i_cpu_req = 1'b0; i_io_ack = 1'b0;
    i_err_clr = clr; clr_last = clr;
    #1 cmp_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_err = 1'b0; clr_last = 1'b0;
    set_idle();
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_rdata = '0;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 32'(o_cpu_ready), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_io_req", 32'(o_io_req), 32'h0);
    chk("rst_ram_en", 32'(o_ram_en), 32'h0);
    chk("rst_rdata", o_cpu_rdata, 32'h0);
    i_rst_n = 1'b1;

    // RAM write 0x0123 <- 0xA5
    run_txn(32'h0000_0123, 1'b1, 32'h0000_00A5, -1, 8'h0, 2, 1'b0, 1'b0, 1'b0);
    chk("wr_latency", 32'(obs_ready_p), 32'd2);
    chk("wr_ram_strobes", 32'(obs_ram_cycles), 32'd1);
    idle_cyc(1'b0);

    // RAM read 0x0010 returning 0x5A
    run_txn(32'h0000_0010, 1'b1, 32'h0000_005A, -1, 8'h0, 0, 1'b0, 1'b0, 1'b0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, -1, 8'h0, 1, 1'b0, 1'b0, 1'b0);
    chk("rd_latency", 32'(obs_ready_p), 32'd3);
    chk("rd_data", obs_rdata, 32'h0000_005A);
    run_txn(32'h0000_0123, 1'b0, 32'h0, -1, 8'h0, 0, 1'b0, 1'b0, 1'b0);
    chk("rd_back", obs_rdata, 32'h0000_00A5);

    // I/O read 0x9F22, ack four cycles in, data 0x7E
    run_txn(32'h0000_9F22, 1'b0, 32'h0, 4, 8'h7E, 1, 1'b0, 1'b0, 1'b0);
    chk("io_rd_data", obs_rdata, 32'h0000_007E);
    chk("io_rd_addr", 32'(obs_io_addr), 32'h22);
    chk("io_rd_err", 32'(obs_err), 32'h0);
    chk("io_rd_req_cycles", 32'(obs_io_cycles), 32'd5);

    // I/O write 0x9F01, no ack: timeout
    run_txn(32'h0000_9F01, 1'b1, 32'h0000_0033, -1, 8'h0, 1, 1'b0, 1'b0, 1'b0);
    chk("to_req_cycles", 32'(obs_io_cycles), 32'd15);
    chk("to_latency", 32'(obs_ready_p), 32'd16);
    chk("to_err", 32'(obs_err), 32'h1);
    idle_cyc(1'b1);
    idle_cyc(1'b0);
    chk("err_clr", 32'(o_err), 32'h0);

    // ack on the terminal cycle wins; one cycle later it is ignored
    run_txn(32'h0000_9F10, 1'b0, 32'h0, T-1, 8'h33, 0, 1'b0, 1'b0, 1'b0);
    chk("ack_edge_data", obs_rdata, 32'h0000_0033);
    chk("ack_edge_err", 32'(obs_err), 32'h0);
    chk("ack_edge_cycles", 32'(obs_io_cycles), 32'd15);
    run_txn(32'h0000_9F11, 1'b0, 32'h0, T, 8'h44, 0, 1'b0, 1'b0, 1'b0);
    chk("ack_late_data", obs_rdata, 32'hFFFF_FFFF);
    chk("ack_late_err", 32'(obs_err), 32'h1);
    idle_cyc(1'b1);

    // unmapped read with err_clr on the accepting edge: set wins
    run_txn(32'h0001_0000, 1'b0, 32'h0, -1, 8'h0, 1, 1'b0, 1'b1, 1'b0);
    chk("unm_latency", 32'(obs_ready_p), 32'd1);
    chk("unm_rdata", obs_rdata, 32'h0);
    chk("unm_err", 32'(obs_err), 32'h1);
    chk("unm_strobes", 32'(obs_ram_cycles + obs_io_cycles), 32'd0);

    // reset pulse during an I/O wait, request held across it
    tick(); step_err(1'b0); set_idle();
    exp_addr = 32'h0000_9F40; exp_we = 1'b0;
    i_cpu_req = 1'b1; i_cpu_addr = 32'h0000_9F40; i_cpu_we = 1'b0;
    i_err_clr = 1'b0; clr_last = 1'b0; i_io_ack = 1'b0;
    #1 cmp_cycle();
    for (int p = 0; p < 3; p++) begin
      tick(); step_err(1'b0); set_idle(); exp_io_req = 1'b1;
      i_cpu_addr = {24'h00009F, 8'h40};
      #1 cmp_cycle();
    end
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_io_req", 32'(o_io_req), 32'h0);
    chk("rst_mid_ready", 32'(o_cpu_ready), 32'h0);
    chk("rst_mid_err", 32'(o_err), 32'h0);
    model_err = 1'b0;
    set_idle();
    tick();
    #1 cmp_cycle();
    tick();
    i_rst_n = 1'b1;
    run_txn(32'h0000_9F41, 1'b0, 32'h0, 2, 8'hC3, 1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_latency", 32'(obs_ready_p), 32'd4);
    chk("post_rst_data", obs_rdata, 32'h0000_00C3);
    chk("post_rst_req_cycles", 32'(obs_io_cycles), 32'd3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [31:0] a;
      bit          we;
      int          ack_c;
      kind = $urandom_range(0, 9);
      we = 1'($urandom);
      ack_c = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T+2));
      if (kind <= 3 || (kind <= 5 && wr_q.size() == 0)) begin
        a = 32'($urandom_range(0, 511)); we = 1'b1;
      end else if (kind <= 5) begin
        a = wr_q[$urandom_range(0, wr_q.size()-1)]; we = 1'b0;
      end else if (kind <= 8) begin
        a = {24'h00009F, 8'($urandom)};
      end else begin
        a = $urandom;
        if (a < 32'h0001_0000) a = a | 32'h0001_0000;
      end
      run_txn(a, we, $urandom, ack_c, 8'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cyc(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
